// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    WAIT_DONE,
    RUN,
    ERROR
  } loader_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; the completed word and its
// strobe are presented combinationally in the cycle the final byte arrives.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic [1:0]  byte_idx
);

  logic [23:0] lanes;

  assign word_valid = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign word_out   = {byte_in, lanes};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (clr) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (byte_valid) begin
      case (byte_idx)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: lanes        <= lanes;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Drives the instruction-memory load port: packs UART bytes, pads with NOPs to DEPTH
// writes, then releases the core once the memory reports load_done.
module prog_loader #(
  parameter int          DEPTH       = 256,
  parameter int          CNT_W       = $clog2(DEPTH) + 1,
  parameter logic [31:0] NOP_INSTR   = prog_loader_pkg::NOP_INSTR,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             finish,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             mem_load_done,
  output logic             load_en,
  output logic [31:0]      load_inst,
  output logic             cpu_run,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);
  import prog_loader_pkg::*;

  localparam int               TMR_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMO_C   = TMR_W'(TIMEOUT_CYC);

  loader_state_t    state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [CNT_W-1:0] count_next, count_inc;
  logic             load_en_next;
  logic [31:0]      load_inst_next;
  logic             pack_clr, pack_vld, pack_word_vld;
  logic [31:0]      pack_word;
  logic [1:0]       byte_idx;

  // Index stays at zero outside LOAD, and finish throws away any partial word.
  assign pack_vld = rx_valid && (state == LOAD);
  assign pack_clr = (state != LOAD) || finish;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pack_clr),
    .byte_in    (rx_data),
    .byte_valid (pack_vld),
    .word_out   (pack_word),
    .word_valid (pack_word_vld),
    .byte_idx   (byte_idx)
  );

  always_comb begin
    state_next     = state;
    timer_next     = timer;
    count_next     = word_count;
    load_en_next   = 1'b0;
    load_inst_next = load_inst;
    count_inc      = (word_count < DEPTH_C) ? word_count + CNT_W'(1) : word_count;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          timer_next = '0;
          count_next = '0;
        end
      end
      LOAD: begin
        if ((timer == TMO_C) || (mem_load_done && (word_count < DEPTH_C))) begin
          state_next = ERROR;
        end else begin
          timer_next = (rx_valid || (byte_idx == 2'd0)) ? '0 : timer + TMR_W'(1);
          if (pack_word_vld) begin
            load_en_next   = 1'b1;
            load_inst_next = pack_word;
            count_next     = count_inc;
          end
          if (count_next == DEPTH_C) state_next = WAIT_DONE;
          else if (finish)           state_next = PAD;
        end
      end
      PAD: begin
        if (mem_load_done && (word_count < DEPTH_C)) begin
          state_next = ERROR;
        end else if (word_count == DEPTH_C) begin
          state_next = WAIT_DONE;
        end else begin
          load_en_next   = 1'b1;
          load_inst_next = NOP_INSTR;
          count_next     = count_inc;
          if (count_inc == DEPTH_C) state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mem_load_done) state_next = RUN;
      end
      RUN:     state_next = RUN;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      word_count <= '0;
      load_en    <= 1'b0;
      load_inst  <= '0;
      cpu_run    <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      timer      <= timer_next;
      word_count <= count_next;
      load_en    <= load_en_next;
      load_inst  <= load_inst_next;
      cpu_run    <= (state_next == RUN);
      busy       <= (state_next == LOAD) || (state_next == PAD) || (state_next == WAIT_DONE);
      error      <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued by the stimulus
// and checked by an independent monitor on the falling edge.
module tb_prog_loader;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]      inst;
    logic [CNT_W-1:0] cnt;
  } wr_t;

  logic             clk, rst_n, start, finish, rx_valid, mem_load_done, force_done;
  logic [7:0]       rx_data;
  logic             load_en, cpu_run, busy, error;
  logic [31:0]      load_inst;
  logic [CNT_W-1:0] word_count;

  int  n_pass = 0;
  int  n_total = 0;
  int  mem_wr;
  wr_t exp_q[$];

  logic [7:0] t1_bytes [16] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h01, 8'h00,
                                8'h93, 8'h80, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
  logic [7:0] t2_bytes [5]  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hAA};

  prog_loader #(.DEPTH(DEPTH), .TIMEOUT_CYC(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .finish        (finish),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .mem_load_done (mem_load_done),
    .load_en       (load_en),
    .load_inst     (load_inst),
    .cpu_run       (cpu_run),
    .busy          (busy),
    .error         (error),
    .word_count    (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: raises load_done once DEPTH writes have landed, cleared only by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mem_wr <= 0;
    else if (load_en) mem_wr <= mem_wr + 1;
  end
  assign mem_load_done = force_done || (mem_wr >= DEPTH);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && load_en) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: load_inst=%h word_count=%0d, none expected",
                 load_inst, word_count);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_inst", load_inst, e.inst);
        chk("write_count", 32'(word_count), 32'(e.cnt));
      end
    end
  end

  task automatic push(input logic [31:0] inst, input int cnt);
    wr_t e;
    e.inst = inst;
    e.cnt  = CNT_W'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fin);
    @(negedge clk);
    start = 1'b0; rx_data = b; rx_valid = 1'b1; finish = fin;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; finish = 1'b0; rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; finish = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic pulse_finish();
    @(negedge clk);
    start = 1'b0; finish = 1'b1; rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic fin_last);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], (i == 3) ? fin_last : 1'b0);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 40) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; force_done = 1'b0;
    start = 1'b0; finish = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int i;
    rst_n = 1'b0; force_done = 1'b0;
    start = 1'b0; finish = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_load_en", load_en, 0);
    chk("rst_load_inst", load_inst, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    rst_n = 1'b1;

    // Full program, back-to-back bytes
    pulse_start();
    push(32'h0000_0013, 1); push(32'h0001_00B7, 2);
    push(32'h0000_8093, 3); push(32'h0000_006F, 4);
    for (int k = 0; k < 16; k++) send_byte(t1_bytes[k], 1'b0);
    idle(1);
    drain("t1_drain");
    i = 0;
    while (!mem_load_done && i < 10) begin
      @(negedge clk);
      i++;
    end
    chk("t1_done_seen", mem_load_done, 1);
    chk("t1_cpu_run_before", cpu_run, 0);
    @(negedge clk);
    chk("t1_cpu_run_after", cpu_run, 1);
    chk("t1_word_count", word_count, 4);
    chk("t1_busy_run", busy, 0);

    // Early finish with a dangling partial byte
    reset_dut();
    pulse_start();
    push(32'h1234_5678, 1);
    push(32'h0000_0013, 2); push(32'h0000_0013, 3); push(32'h0000_0013, 4);
    for (int k = 0; k < 5; k++) send_byte(t2_bytes[k], 1'b0);
    pulse_finish();
    idle(1);
    drain("t2_drain");
    idle(3);
    chk("t2_cpu_run", cpu_run, 1);
    chk("t2_word_count", word_count, 4);

    // finish coincides with the last byte of word 2
    reset_dut();
    pulse_start();
    push(32'h1122_3344, 1); push(32'hDEAD_BEEF, 2);
    push(32'h0000_0013, 3); push(32'h0000_0013, 4);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b1);
    idle(1);
    drain("t3_drain");
    idle(4);
    chk("t3_cpu_run", cpu_run, 1);
    chk("t3_word_count", word_count, 4);

    // Inter-byte timeout
    reset_dut();
    pulse_start();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    idle(1);
    repeat (9) @(negedge clk);
    chk("t4_no_early_error", error, 0);
    repeat (2) @(negedge clk);
    chk("t4_error", error, 1);
    chk("t4_busy", busy, 0);
    pulse_start();
    idle(3);
    chk("t4_start_ignored_busy", busy, 0);
    chk("t4_error_sticky", error, 1);
    chk("t4_word_count", word_count, 0);

    // load_done arriving early
    reset_dut();
    pulse_start();
    push(32'h0403_0201, 1); push(32'h0807_0605, 2);
    send_word(32'h0403_0201, 1'b0);
    send_word(32'h0807_0605, 1'b0);
    idle(1);
    drain("t5_drain");
    force_done = 1'b1;
    idle(2);
    chk("t5_error", error, 1);
    chk("t5_cpu_run", cpu_run, 0);
    chk("t5_busy", busy, 0);
    send_word(32'h0C0B_0A09, 1'b0);
    idle(3);
    chk("t5_word_count_frozen", word_count, 2);
    chk("t5_cpu_run_still", cpu_run, 0);

    // Asynchronous reset mid-word
    reset_dut();
    pulse_start();
    push(32'hCAFE_BABE, 1);
    send_word(32'hCAFE_BABE, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    idle(1);
    drain("t6_drain");
    chk("t6_busy_before", busy, 1);
    chk("t6_count_before", word_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_load_en", load_en, 0);
    chk("t6_async_load_inst", load_inst, 0);
    chk("t6_async_cpu_run", cpu_run, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_error", error, 0);
    chk("t6_async_word_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'h7777_7777, 1'b0);
    idle(3);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_count", word_count, 0);
    pulse_start();
    push(32'h0403_0201, 1);
    send_word(32'h0403_0201, 1'b0);
    idle(1);
    drain("t6_restart_drain");
    chk("t6_restart_busy", busy, 1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory load port.
- Takes a byte stream from the UART receiver and packs it into 32-bit little-endian words.
- Issues exactly DEPTH single-cycle load_en writes, and pads with NOPs if the host finishes early.
- Waits for the memory's load_done, then releases the core via cpu_run. Sits between uart_rx and instr_mem in the top level.

Parameters:
- DEPTH, 256, number of words the memory expects before it raises load_done.
- CNT_W, $clog2(DEPTH)+1, width of word_count.
- NOP_INSTR, 32'h0000_0013, pad word (addi x0,x0,0).
- TIMEOUT_CYC, 100000, maximum idle cycles between bytes inside one word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a load session.
- finish  in  1  one-cycle pulse: host has no more words; pad the remainder.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid this cycle. Single-cycle pulse, no backpressure.
- mem_load_done  in  1  load_done from the instruction memory.
- load_en  out  1  write strobe to the memory.
- load_inst  out  32  word being written.
- cpu_run  out  1  high means the core may leave reset.
- busy  out  1  session in progress.
- error  out  1  sticky fault flag.
- word_count  out  CNT_W  words issued this session.

Behaviour:
- Reset: state IDLE. load_en=0, load_inst=0, cpu_run=0, busy=0, error=0, word_count=0. Byte index and timeout timer are 0.
- All outputs are registered.
- States: IDLE, LOAD, PAD, WAIT_DONE, RUN, ERROR.
- busy=1 in LOAD, PAD and WAIT_DONE.
- IDLE:
  - start -> LOAD; clear byte index, timer, word_count.
  - rx_valid and finish are ignored.
- LOAD, byte packing:
  - Each rx_valid byte goes to lane byte_idx: first byte -> [7:0], fourth byte -> [31:24].
  - On the 4th byte, the next cycle has load_en=1 for exactly one cycle, load_inst=assembled word, word_count+1.
  - Latency from 4th rx_valid to load_en is 1 cycle. Back-to-back rx_valid every cycle must be sustained.
- LOAD, completion: the pulse that makes word_count==DEPTH transitions to WAIT_DONE in the same edge. Later bytes are ignored.
- LOAD, finish:
  - Any partial word (byte_idx!=0) is discarded.
  - Next state is PAD, or WAIT_DONE if word_count==DEPTH.
  - If finish coincides with the 4th byte, that word is still written; PAD begins the cycle after that write.
- PAD:
  - load_en=1 every cycle with load_inst=NOP_INSTR; word_count increments each cycle.
  - When word_count reaches DEPTH, go to WAIT_DONE. load_en is 0 from that point.
- Timeout:
  - In LOAD with byte_idx!=0, the timer counts cycles with no rx_valid and resets on each byte.
  - timer==TIMEOUT_CYC -> ERROR.
  - With byte_idx==0 the timer is held at 0 (pauses between words are legal).
- Sync check: mem_load_done=1 while in LOAD or PAD with word_count<DEPTH -> ERROR.
- WAIT_DONE: when mem_load_done=1, go to RUN; cpu_run=1 from the next cycle.
- RUN: terminal. cpu_run stays 1; start, finish and rx are ignored.
- ERROR:
  - error=1, load_en=0, cpu_run=0. Terminal.
  - Exit only via rst_n, because the memory's internal write pointer is only cleared by reset.
- start outside IDLE is ignored.
- word_count saturates at DEPTH and never wraps.
- rst_n assertion mid-session aborts immediately to reset values. A partially loaded program is never run.

Decomposition:
- prog_loader_pkg holds:
  - loader_state_t enum (the six states);
  - NOP_INSTR constant;
  - BYTES_PER_WORD=4.
- One sub-module, byte_packer:
  - ports: clk, rst_n, clr, byte_in, byte_valid, word_out[31:0], word_valid (1-cycle), byte_idx[1:0];
  - owns the lane shifting and the index counter.
- The FSM, timer and counters stay in prog_loader.

Test Plan:
- DEPTH=4. start, then bytes 13 00 00 00 | B7 00 01 00 | 93 80 00 00 | 6F 00 00 00 back-to-back, mem_load_done model raised after the 4th write -> four load_en pulses with 32'h00000013, 32'h000100B7, 32'h00008093, 32'h0000006F; word_count=4; cpu_run=1 one cycle after mem_load_done.
- DEPTH=4. start, 5 bytes 78 56 34 12 AA, then finish -> one write 32'h12345678; byte AA dropped; 3 consecutive NOP writes 32'h00000013; then WAIT_DONE.
- finish in the same cycle as the 4th byte of word 2 -> word 2 written, then 2 NOPs. Exactly 4 total load_en pulses.
- TIMEOUT_CYC=10. Send 2 bytes, then idle 10 cycles -> error=1, busy=0, load_en never asserted. A following start is ignored.
- mem_load_done forced high after the 2nd write -> error=1, cpu_run stays 0.
- Assert rst_n low mid-word in LOAD -> all outputs 0 asynchronously. After release, rx bytes are ignored until start.
